// File: rtl/dac_tgc_seq_pkg.sv
// Shared types and constants for the TGC curve player and the DAC shifter it feeds.
package dac_tgc_seq_pkg;

    localparam int DAC_W        = 8;
    localparam int N_CH         = 4;
    localparam int FRAME_LEN    = 16;
    localparam int MIN_STEP_DEF = FRAME_LEN + 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT
    } tgc_state_e;

    typedef logic [N_CH-1:0][DAC_W-1:0] dac_codes_t;

    // A step shorter than one shifter frame would overrun the serializer.
    function automatic logic [15:0] eff_period(input logic [15:0] div,
                                               input logic [15:0] min_p);
        return (div < min_p) ? min_p : div;
    endfunction

endpackage

// File: rtl/dac_tgc_seq_ram.sv
// Four-bank curve memory: one host write port, one shared registered read port.
// A read and write to the same address in one cycle returns the old data.
module dac_tgc_ram
    import dac_tgc_seq_pkg::*;
#(
    parameter int N_POINTS = 64,
    parameter int PT_W     = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [1:0]        wr_ch_i,
    input  logic [PT_W-1:0]   wr_addr_i,
    input  logic [DAC_W-1:0]  wr_data_i,
    input  logic              rd_en_i,
    input  logic [PT_W-1:0]   rd_addr_i,
    output dac_codes_t        rd_data_o
);

    logic [DAC_W-1:0] mem [N_CH][N_POINTS];
    dac_codes_t       rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_ch_i][wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                rd_data_q[ch] <= mem[ch][rd_addr_i];
            end
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/dac_tgc_seq.sv
// TGC curve player: steps through the stored per-channel gain curve after each start
// and hands each point to the DAC shifter with a sync strobe. DAC_TGC_PARK_EN adds a park strobe.
//
// state    | meaning
// ST_IDLE  | no playback; outputs hold last codes
// ST_FETCH | read address = current point
// ST_ISSUE | RAM data valid; load codes, strobe sync, arm step counter
// ST_WAIT  | count down to the next point
module dac_tgc_seq
    import dac_tgc_seq_pkg::*;
#(
    parameter int         N_POINTS  = 64,
    parameter int         PT_W      = 6,
    parameter int         MIN_STEP  = MIN_STEP_DEF,
    parameter logic [7:0] PARK_CODE = 8'h00
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [15:0]      i_step_div,
    input  logic             i_wr_en,
    input  logic [1:0]       i_wr_ch,
    input  logic [PT_W-1:0]  i_wr_addr,
    input  logic [7:0]       i_wr_data,
    output logic [7:0]       o_data_spi_0,
    output logic [7:0]       o_data_spi_1,
    output logic [7:0]       o_data_spi_2,
    output logic [7:0]       o_data_spi_3,
    output logic             o_sync,
    output logic             o_busy,
    output logic [PT_W-1:0]  o_point,
    output logic             o_done
);

    localparam logic [15:0]     MIN_P   = 16'(MIN_STEP);
    localparam logic [PT_W-1:0] LAST_PT = PT_W'(N_POINTS - 1);

    tgc_state_e      state_q;
    logic [PT_W-1:0] idx_q;
    logic [PT_W-1:0] point_q;
    logic [15:0]     per_q;
    logic [15:0]     cnt_q;
    logic [15:0]     per_d;
    dac_codes_t      codes_q;
    dac_codes_t      rd_codes;
    logic            sync_q;
    logic            done_q;
    logic            busy_q;
`ifdef DAC_TGC_PARK_EN
    logic            park_q;
`else
    logic            unused_park;
    assign unused_park = ^PARK_CODE;
`endif

    assign per_d = eff_period(i_step_div, MIN_P);

    dac_tgc_ram #(
        .N_POINTS (N_POINTS),
        .PT_W     (PT_W)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (i_wr_en),
        .wr_ch_i   (i_wr_ch),
        .wr_addr_i (i_wr_addr),
        .wr_data_i (i_wr_data),
        .rd_en_i   (state_q == ST_FETCH),
        .rd_addr_i (idx_q),
        .rd_data_o (rd_codes)
    );

    // Counter is loaded with P-3 so FETCH and ISSUE complete a P-clock step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            point_q <= '0;
            per_q   <= '0;
            cnt_q   <= '0;
            codes_q <= '0;
            sync_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef DAC_TGC_PARK_EN
            park_q  <= 1'b0;
`endif
        end else begin
            sync_q <= 1'b0;
            done_q <= 1'b0;
            if (i_start) begin
                // Restart has priority over any in-flight step, including the last issue.
                state_q <= ST_FETCH;
                idx_q   <= '0;
                per_q   <= per_d;
                busy_q  <= 1'b1;
`ifdef DAC_TGC_PARK_EN
                park_q  <= 1'b0;
`endif
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        busy_q <= 1'b0;
                    end
                    ST_FETCH: begin
                        state_q <= ST_ISSUE;
                    end
                    ST_ISSUE: begin
                        sync_q  <= 1'b1;
                        point_q <= idx_q;
                        cnt_q   <= per_q - 16'd3;
`ifdef DAC_TGC_PARK_EN
                        if (park_q) begin
                            codes_q <= {N_CH{PARK_CODE}};
                            done_q  <= 1'b1;
                            park_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            codes_q <= rd_codes;
                            state_q <= ST_WAIT;
                            if (idx_q == LAST_PT) begin
                                park_q <= 1'b1;
                            end
                        end
`else
                        codes_q <= rd_codes;
                        if (idx_q == LAST_PT) begin
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_WAIT;
                        end
`endif
                    end
                    ST_WAIT: begin
                        if (cnt_q == 16'd0) begin
                            state_q <= ST_FETCH;
`ifdef DAC_TGC_PARK_EN
                            if (!park_q) begin
                                idx_q <= idx_q + PT_W'(1);
                            end
`else
                            idx_q <= idx_q + PT_W'(1);
`endif
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_data_spi_0 = codes_q[0];
    assign o_data_spi_1 = codes_q[1];
    assign o_data_spi_2 = codes_q[2];
    assign o_data_spi_3 = codes_q[3];
    assign o_sync       = sync_q;
    assign o_busy       = busy_q;
    assign o_point      = point_q;
    assign o_done       = done_q;

endmodule

// File: doc/dac_tgc_seq.md
Name: dac_tgc_seq

Overview:
- Upstream feeder for the 4-channel serial DAC shifter. Plays a stored per-channel 8-bit gain curve (TGC profile) after each acquisition start.
- Presents the 4 channel codes plus a one-cycle sync strobe once per curve step; the shifter serializes each update in 16 clocks.
- Host loads the curves through a simple write port at any time.

Parameters:
- N_POINTS, 64, curve points per channel (power of 2)
- PT_W, 6, log2(N_POINTS)
- MIN_STEP, 18, minimum clocks between sync strobes (16-bit frame + 2 margin)
- PARK_CODE, 8'h00, code written to all channels after the curve ends (optional feature only)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle acquisition start (probe fire)
- i_step_div  in  16  clocks per curve point; latched at start
- i_wr_en  in  1  host curve write strobe
- i_wr_ch  in  2  channel select for write
- i_wr_addr  in  PT_W  point index for write
- i_wr_data  in  8  curve code
- o_data_spi_0..o_data_spi_3  out  8 each  channel codes to DAC shifter
- o_sync  out  1  one-cycle load strobe to DAC shifter
- o_busy  out  1  curve playback active
- o_point  out  PT_W  index of the last issued point
- o_done  out  1  one-cycle pulse after the final point is issued

Behaviour:
- Reset (async, rst_n=0): state IDLE; o_data_spi_* = 0; o_sync = 0; o_busy = 0; o_point = 0; o_done = 0; step counter = 0. Curve RAM is not cleared.
- Curve RAM: 4 banks, each N_POINTS x 8.
  - Synchronous write on i_wr_en to bank i_wr_ch, address i_wr_addr.
  - Registered read, 1-cycle latency, shared read address for all banks.
  - Same-address read/write in one cycle returns old data.
- Latched period: P = max(i_step_div, MIN_STEP), taken at i_start.
- States:
  - IDLE: on i_start -> FETCH with idx = 0. o_busy = 1 from the cycle after i_start.
  - FETCH: drive read address = idx -> ISSUE.
  - ISSUE: register the 4 RAM outputs into o_data_spi_*, set o_sync = 1 for exactly one cycle, o_point = idx, load counter = P-3 -> WAIT.
    - If idx = N_POINTS-1: pulse o_done together with o_sync and go to IDLE instead (o_busy drops the next cycle).
  - WAIT: decrement the counter; at 0, idx++ -> FETCH.
- Latency: i_start sampled at edge E0 -> o_sync and data visible after edge E2.
- Step timing: consecutive o_sync pulses are exactly P clocks apart (edge to edge).
- o_data_spi_* change only in the o_sync cycle; between strobes they hold their value.
- i_start while busy: abort the current run and restart at FETCH with idx = 0; P is re-latched.
  - A sync already issued is not retracted.
  - The next sync follows 2 clocks after the restart, even if fewer than MIN_STEP clocks have passed. The host must not retrigger faster than MIN_STEP.
- i_start coincident with the final ISSUE: the restart wins and no o_done is issued.
- Host writes during playback are allowed and take effect on the next fetch of that address.
- After the run, outputs hold the last point's codes.

Optional Feature:
- Macro: DAC_TGC_PARK_EN.
- Defined: after the final point, WAIT P clocks, then issue one additional o_sync with all four o_data_spi_* = PARK_CODE. o_done pulses with this park strobe, not with the last point. o_point stays N_POINTS-1.
- Undefined: no park strobe; the last curve codes hold; PARK_CODE is unused.

Decomposition:
- Shared package:
  - state enum (IDLE, FETCH, ISSUE, WAIT)
  - MIN_STEP default
  - DAC code width (8) and channel count (4)
  - DAC frame length (16), also used by the shifter
- One sub-module: dac_tgc_ram, 4-bank single-write/shared-read curve memory with registered output. FSM and counter stay in the top module.

Test Plan:
- Load all banks with code = ch*64+idx, i_step_div=20, pulse i_start -> o_sync first visible 2 clocks after start, then every 20 clocks. Point k gives data {k, 64+k, 128+k, 192+k}. o_done on point 63; o_busy low the next cycle.
- i_step_div=5 -> effective period 18 clocks between o_sync pulses. i_step_div=0 -> also 18.
- Pulse i_start again at point 10 -> next o_sync 2 clocks later carries point 0 data. No o_done at the old position; the full 64 points follow.
- Write bank 2, addr 5 = 8'hA5 in the same cycle its FETCH occurs -> old value issued at point 5. A rerun issues 8'hA5.
- Assert rst_n=0 mid-WAIT -> outputs immediately 0, o_busy=0, no further o_sync. RAM contents are kept, so a restart after release plays the same curve.
- With DAC_TGC_PARK_EN and PARK_CODE=8'h10, 64 points, P=18 -> 65 o_sync pulses; the 65th carries 8'h10 on all channels, arrives 18 clocks after point 63, and coincides with o_done.
